// File: rtl/pia_port_channel_if.sv
// CPU-side register bus of one PIA port channel: selects, direction and data.
// The master drives the access; the slave (the channel) returns read data and drive enable.
interface pia_port_channel_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cs;
    logic             rs;
    logic             rw;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;

    modport master (
        output cs, rs, rw, bus_in,
        input  bus_out, bus_oe
    );

    modport slave (
        input  cs, rs, rw, bus_in,
        output bus_out, bus_oe
    );
endinterface

// File: rtl/pia_port_channel.sv
// One 6520-style peripheral channel: DDR, OR, CR and a synchronised,
// edge-selectable CA1 interrupt flag behind a small register bus.
module pia_port_channel #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pia_port_channel_if.slave     bus,
    input  logic [WIDTH-1:0]      pin_in,
    output logic [WIDTH-1:0]      pin_out,
    output logic [WIDTH-1:0]      pin_dir,
    input  logic                  ca1,
    output logic                  irq_n
);
    localparam int unsigned CR_W = 7;

    logic [WIDTH-1:0]       ddr_q, ddr_d;
    logic [WIDTH-1:0]       or_q, or_d;
    logic [CR_W-1:0]        cr_q, cr_d;
    logic                   flag_q, flag_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    logic wr_en;
    logic or_rd;
    logic ca1_s;
    logic edge_seen;

    assign ca1_s = sync_q[SYNC_STAGES-1];

    // Next-state: register writes, CA1 edge detection, flag set/clear
    always_comb begin
        ddr_d  = ddr_q;
        or_d   = or_q;
        cr_d   = cr_q;
        flag_d = flag_q;
        sync_d = sync_q;
        hist_d = ca1_s;

        wr_en     = bus.cs & ~bus.rw;
        or_rd     = bus.cs & bus.rw & ~bus.rs & cr_q[2];
        // Rising edge lands on 1, falling on 0, so the new level must equal CR[1]
        edge_seen = (ca1_s != hist_q) && (ca1_s == cr_q[1]);

        if (wr_en) begin
            if (bus.rs) begin
                cr_d = bus.bus_in[CR_W-1:0];
            end else if (cr_q[2]) begin
                or_d = bus.bus_in;
            end else begin
                ddr_d = bus.bus_in;
            end
        end

        // A set on the same edge as an OR-read clear must win
        flag_d = edge_seen | (flag_q & ~or_rd);

        sync_d[0] = ca1;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ddr_q  <= '0;
            or_q   <= '0;
            cr_q   <= '0;
            flag_q <= 1'b0;
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            ddr_q  <= ddr_d;
            or_q   <= or_d;
            cr_q   <= cr_d;
            flag_q <= flag_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Read path is combinational so the CPU sees data within the access cycle
    always_comb begin
        bus.bus_oe  = bus.cs & bus.rw;
        bus.bus_out = '0;
        if (bus.bus_oe) begin
            if (bus.rs) begin
                bus.bus_out = WIDTH'({flag_q, cr_q});
            end else if (cr_q[2]) begin
                bus.bus_out = (ddr_q & or_q) | (~ddr_q & pin_in);
            end else begin
                bus.bus_out = ddr_q;
            end
        end
    end

    assign pin_out = or_q;
    assign pin_dir = ddr_q;
    assign irq_n   = ~(flag_q & cr_q[0]);

endmodule

// File: tb/tb_pia_port_channel.sv
// Bench for pia_port_channel: per-cycle comparison against an event-log model
// of the channel, plus directed register/IRQ scenarios with literal expectations.
module tb_pia_port_channel;
    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic         clk;
    logic         reset;
    logic [W-1:0] pin_in;
    logic [W-1:0] pin_out;
    logic [W-1:0] pin_dir;
    logic         ca1;
    logic         irq_n;

    pia_port_channel_if #(.WIDTH(W)) bus_if ();

    pia_port_channel #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_dir (pin_dir),
        .ca1     (ca1),
        .irq_n   (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register values plus a log of ca1 samples taken since the last reset
    logic [W-1:0] m_ddr, m_or;
    logic [7:0]   m_cr;
    logic         m_flag;
    bit           ca_log[$];

    function automatic bit ca_at(int e);
        if (e < 0) return 1'b0;
        return ca_log[e];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ddr  = '0;
            m_or   = '0;
            m_cr   = '0;
            m_flag = 1'b0;
            ca_log.delete();
        end else begin
            int m;
            bit now_v, prev_v, set_f, clr_f;
            m      = ca_log.size();
            // The level sampled S edges ago is what the detector compares now
            now_v  = ca_at(m - int'(S));
            prev_v = ca_at(m - int'(S) - 1);
            set_f  = m_cr[1] ? (!prev_v && now_v) : (prev_v && !now_v);
            clr_f  = bus_if.cs && bus_if.rw && !bus_if.rs && m_cr[2];
            if (bus_if.cs && !bus_if.rw) begin
                if (bus_if.rs)      m_cr  = {1'b0, bus_if.bus_in[6:0]};
                else if (m_cr[2])   m_or  = bus_if.bus_in;
                else                m_ddr = bus_if.bus_in;
            end
            m_flag = set_f || (m_flag && !clr_f);
            ca_log.push_back(ca1);
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic         e_oe;
            logic [W-1:0] e_out;
            e_oe  = bus_if.cs && bus_if.rw;
            e_out = '0;
            if (e_oe) begin
                if (bus_if.rs) begin
                    e_out = {m_flag, m_cr[6:0]};
                end else if (m_cr[2]) begin
                    for (int i = 0; i < int'(W); i++)
                        e_out[i] = m_ddr[i] ? m_or[i] : pin_in[i];
                end else begin
                    e_out = m_ddr;
                end
            end
            chk("cyc_bus_oe", 32'(bus_if.bus_oe), 32'(e_oe));
            chk("cyc_bus_out", 32'(bus_if.bus_out), 32'(e_out));
            chk("cyc_pin_out", 32'(pin_out), 32'(m_or));
            chk("cyc_pin_dir", 32'(pin_dir), 32'(m_ddr));
            chk("cyc_irq_n", 32'(irq_n), 32'(!(m_flag && m_cr[0])));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus_if.cs = 1'b0;
        bus_if.rw = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic rs_v, input logic [W-1:0] d);
        bus_if.cs     = 1'b1;
        bus_if.rw     = 1'b0;
        bus_if.rs     = rs_v;
        bus_if.bus_in = d;
        cyc();
        bus_if.cs     = 1'b0;
    endtask

    task automatic rd(input logic rs_v, input logic [W-1:0] exp, input string name);
        bus_if.cs = 1'b1;
        bus_if.rw = 1'b1;
        bus_if.rs = rs_v;
        @(negedge clk);
        chk(name, 32'(bus_if.bus_out), 32'(exp));
        cyc();
        bus_if.cs = 1'b0;
        bus_if.rw = 1'b0;
    endtask

    task automatic at_neg_irq(input logic exp, input string name);
        @(negedge clk);
        chk(name, 32'(irq_n), 32'(exp));
    endtask

    initial begin
        reset         = 1'b1;
        ca1           = 1'b1;
        pin_in        = '0;
        bus_if.cs     = 1'b0;
        bus_if.rs     = 1'b0;
        bus_if.rw     = 1'b0;
        bus_if.bus_in = '0;
        cyc();
        chk_en = 1'b1;

        // Reset with ca1 high and random bus traffic
        repeat (4) begin
            bus_if.cs     = 1'($urandom_range(0, 1));
            bus_if.rw     = 1'($urandom_range(0, 1));
            bus_if.rs     = 1'($urandom_range(0, 1));
            bus_if.bus_in = W'($urandom);
            cyc();
        end
        reset     = 1'b0;
        bus_if.cs = 1'b0;
        bus_if.rw = 1'b0;
        @(negedge clk);
        chk("rst_pin_dir", 32'(pin_dir), 32'h00);
        chk("rst_pin_out", 32'(pin_out), 32'h00);
        chk("rst_irq_n", 32'(irq_n), 32'h1);
        chk("rst_bus_oe", 32'(bus_if.bus_oe), 32'h0);
        chk("rst_bus_out", 32'(bus_if.bus_out), 32'h00);
        cyc();
        rd(1'b1, 8'h00, "rst_cr_read");
        idle(10);
        rd(1'b1, 8'h00, "rst_cr_after_10");

        // DDR/OR mux
        wr(1'b1, 8'h00);
        wr(1'b0, 8'hF0);
        wr(1'b1, 8'h04);
        wr(1'b0, 8'hA5);
        pin_in = 8'h3C;
        rd(1'b0, 8'hAC, "mux_or_read");
        @(negedge clk);
        chk("mux_pin_out", 32'(pin_out), 32'hA5);
        chk("mux_pin_dir", 32'(pin_dir), 32'hF0);
        cyc();
        wr(1'b1, 8'h00);
        rd(1'b0, 8'hF0, "mux_ddr_read");

        // Rising-edge IRQ with two-stage latency
        wr(1'b1, 8'h06);
        ca1 = 1'b0;
        idle(4);
        wr(1'b1, 8'h07);
        ca1 = 1'b1;
        cyc();
        at_neg_irq(1'b1, "rise_k");
        cyc();
        at_neg_irq(1'b1, "rise_k1");
        cyc();
        at_neg_irq(1'b0, "rise_k2");
        cyc();
        rd(1'b1, 8'h87, "rise_cr_flag");
        rd(1'b0, 8'hAC, "rise_or_read");
        at_neg_irq(1'b1, "rise_cleared");
        cyc();
        rd(1'b1, 8'h07, "rise_cr_clear");

        // Edge selectivity
        ca1 = 1'b0;
        idle(4);
        wr(1'b1, 8'h05);
        ca1 = 1'b1;
        idle(4);
        at_neg_irq(1'b1, "fall_no_rise");
        cyc();
        rd(1'b1, 8'h05, "fall_cr_noflag");
        ca1 = 1'b0;
        cyc();
        cyc();
        at_neg_irq(1'b1, "fall_k1");
        cyc();
        at_neg_irq(1'b0, "fall_k2");
        cyc();
        rd(1'b0, 8'hAC, "fall_or_read");
        wr(1'b1, 8'h04);
        ca1 = 1'b1;
        idle(4);
        ca1 = 1'b0;
        idle(4);
        at_neg_irq(1'b1, "dis_irq_n");
        cyc();
        rd(1'b1, 8'h84, "dis_cr_flag");
        wr(1'b1, 8'h05);
        at_neg_irq(1'b0, "en_immediate");
        cyc();
        wr(1'b1, 8'h04);
        at_neg_irq(1'b1, "dis_again");
        cyc();
        rd(1'b1, 8'h84, "dis_flag_kept");
        rd(1'b0, 8'hAC, "dis_or_read");
        rd(1'b1, 8'h04, "dis_cr_clear");

        // Set/clear collision
        wr(1'b1, 8'h05);
        ca1 = 1'b1;
        idle(4);
        ca1 = 1'b0;
        cyc();
        cyc();
        bus_if.cs = 1'b1;
        bus_if.rw = 1'b1;
        bus_if.rs = 1'b0;
        @(negedge clk);
        chk("coll_pre_irq", 32'(irq_n), 32'h1);
        chk("coll_or_read", 32'(bus_if.bus_out), 32'hAC);
        cyc();
        bus_if.cs = 1'b0;
        bus_if.rw = 1'b0;
        at_neg_irq(1'b0, "coll_set_wins");
        cyc();
        rd(1'b1, 8'h85, "coll_cr_flag");
        rd(1'b0, 8'hAC, "coll_or_read2");
        at_neg_irq(1'b1, "coll_cleared");
        cyc();

        // Reset mid-operation, with an OR write during reset
        wr(1'b1, 8'h07);
        ca1 = 1'b1;
        cyc();
        reset         = 1'b1;
        bus_if.cs     = 1'b1;
        bus_if.rw     = 1'b0;
        bus_if.rs     = 1'b0;
        bus_if.bus_in = 8'hFF;
        cyc();
        reset     = 1'b0;
        bus_if.cs = 1'b0;
        @(negedge clk);
        chk("mid_pin_out", 32'(pin_out), 32'h00);
        chk("mid_pin_dir", 32'(pin_dir), 32'h00);
        chk("mid_irq_n", 32'(irq_n), 32'h1);
        cyc();
        idle(6);
        rd(1'b1, 8'h00, "mid_cr_noflag");
        wr(1'b1, 8'h07);
        idle(5);
        at_neg_irq(1'b1, "mid_no_late_irq");
        cyc();
        rd(1'b1, 8'h07, "mid_cr_final");

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
